mmio_bridge: RTL
================

# mmio_bridge

Parametrised memory-mapped I/O bridge between the MEM stage of `riscv_core` and an Avalon-MM master port. It generalises the single hard-wired display/JTAG-UART mapping to NUM_CH word-spaced channels, each with a shadow register. Writes are posted through a write buffer of depth WBUF_DEPTH. Reads are non-posted and ordered behind pending writes. The bridge stalls the pipeline only when the buffer is full or a read is outstanding.

## Interface
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- NUM_CH, 4: number of mapped channels, 1..16.
- BASE_ADDR, 32'h108: address of channel 0.
- CH_STRIDE, 4: address distance between channels; a power of two.
- WBUF_DEPTH, 4: write-buffer entries; a power of two, ≥2.

Ports:
- clock  in  1  — single clock, rising edge.
- clear  in  1  — asynchronous, active-high reset.
- mem_addr  in  ADDR_W  — MEM-stage ALU result.
- mem_read  in  1  — MEM-stage MemRead.
- mem_write  in  1  — MEM-stage MemWrite.
- mem_wdata  in  DATA_W  — MEM-stage store data.
- mem_hit  out  1  — mem_addr decodes to a channel; combinational.
- mem_rdata  out  DATA_W  — read return data.
- stall  out  1  — freezes the PC and all pipeline registers; combinational.
- av_address  out  ADDR_W  — Avalon address.
- av_read_n, av_write_n  out  1  — Avalon strobes, active-low.
- av_writedata  out  DATA_W  — Avalon write data.
- av_readdata  in  DATA_W  — Avalon read data.
- av_waitrequest  in  1  — Avalon wait, active-high.
- shadow_out  out  NUM_CH*DATA_W  — last value written per channel; channel k occupies bits [k*DATA_W +: DATA_W].

## Operation
- Decode: off = mem_addr − BASE_ADDR. mem_hit = off < NUM_CH*CH_STRIDE and off mod CH_STRIDE == 0. Channel index = off / CH_STRIDE.
- Buffer: circular, read/write pointers of log2(WBUF_DEPTH)+1 bits. Full when the MSBs differ and the rest are equal; empty when the pointers are equal. Each entry is {address, data}.
- Write hit, buffer not full: push entry, update that channel's shadow register, stall=0.
- Write hit, buffer full: stall=1 and no push. A push in the same cycle as a pop while full is not permitted.
- mem_read and mem_write both high: write wins, read ignored.
- FSM, states IDLE, WR, RD_DRAIN, RD, RD_DONE:
  - IDLE: if read hit → RD_DRAIN, else if buffer non-empty → WR.
  - WR: present buffer head (av_write_n=0). When av_waitrequest=0 at an edge, pop; then return to IDLE.
  - RD_DRAIN: drain the buffer as in WR. Go to RD when empty.
  - RD: av_read_n=0, av_address = mem_addr. When av_waitrequest=0, capture av_readdata into the read register → RD_DONE.
  - RD_DONE: one cycle, then IDLE.
- stall during a read: high combinationally from the cycle a read hit is seen in IDLE through RD, and low in RD_DONE. The core holds all mem_* inputs stable while stall=1.
- Non-hit accesses: no effect, stall=0, mem_rdata=0.

## Timing
- Reset values: mem_rdata=0, stall=0, av_read_n=1, av_write_n=1, av_address=0, av_writedata=0, all shadow registers=0, buffer empty, FSM=IDLE.
- Posted write: shadow visible one edge after accept. av_write_n falls at the earliest one cycle after the push and stays low until the waitrequest-low edge.
- Read latency (empty buffer, zero wait): hit cycle c0 (IDLE); c1 RD_DRAIN; c2 RD, data captured at end of c2; c3 RD_DONE with mem_rdata valid and stall=0. Total 3 stall cycles; each waitrequest cycle adds one.
- Avalon outputs are registered; address, data and strobe change only when the current transfer completes.
- Pointer wrap-around is modular; full/empty are exact at every depth.
- clear mid-transfer: strobes deassert immediately, buffer is discarded and the in-flight transfer is abandoned.

## Configuration
- MMIO_READBACK_EN defined: read hits are served from the shadow register with no Avalon read. This requires an empty buffer to preserve ordering, else RD_DRAIN is used first. With an empty buffer, mem_rdata is combinational and stall=0.
- MMIO_READBACK_EN undefined: every read goes over Avalon as described above.

## Test plan
- Reset mid-write (av_waitrequest=1, av_write_n=0), clear pulsed → av_write_n=1 at once, shadow_out=0, stall=0.
- Write 0xDEADBEEF to 0x108, waitrequest=0 → shadow ch0=0xDEADBEEF next edge; one Avalon write to 0x108 with 0xDEADBEEF; stall never high.
- Five back-to-back writes to 0x10C, waitrequest held 1 → four accepted, stall=1 on the fifth. Release waitrequest → fifth accepted; all five drained in order with wrap-around.
- Two writes pending, then read 0x110 with av_readdata=0x1234 → both writes complete before av_read_n=0; mem_rdata=0x1234 in the cycle stall falls.
- Read 0x104 (miss) and 0x109 (misaligned) → mem_hit=0, no Avalon activity, stall=0.
- With MMIO_READBACK_EN: write 0x55 to 0x114, drain, then read 0x114 → mem_rdata=0x55 same cycle, av_read_n stays 1, stall=0.

Source files
------------

// File: rtl/mmio_bridge.sv
// mmio_bridge: MEM-stage to Avalon-MM bridge with per-channel shadow registers,
// a posted write buffer and reads ordered behind pending writes. Option: MMIO_READBACK_EN.
module mmio_bridge #(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                NUM_CH     = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(32'h108),
    parameter int                CH_STRIDE  = 4,
    parameter int                WBUF_DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic [ADDR_W-1:0]        mem_addr,
    input  logic                     mem_read,
    input  logic                     mem_write,
    input  logic [DATA_W-1:0]        mem_wdata,
    output logic                     mem_hit,
    output logic [DATA_W-1:0]        mem_rdata,
    output logic                     stall,
    output logic [ADDR_W-1:0]        av_address,
    output logic                     av_read_n,
    output logic                     av_write_n,
    output logic [DATA_W-1:0]        av_writedata,
    input  logic [DATA_W-1:0]        av_readdata,
    input  logic                     av_waitrequest,
    output logic [NUM_CH*DATA_W-1:0] shadow_out
);

    localparam int AW  = $clog2(WBUF_DEPTH);
    localparam int SW  = $clog2(CH_STRIDE);
    localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [ADDR_W-1:0] SPAN       = ADDR_W'(NUM_CH * CH_STRIDE);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(CH_STRIDE - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR       = 3'd1,
        RD_DRAIN = 3'd2,
        RD       = 3'd3,
        RD_DONE  = 3'd4
    } state_t;

    state_t state_r, state_n;

    logic [ADDR_W-1:0]        off_s;
    logic [CHW-1:0]           ch_s;
    logic                     hit_s, wr_hit_s, rd_hit_s;
    logic [AW:0]              wptr_r, rptr_r, wptr_n, rptr_n;
    logic                     full_s, empty_s, empty_n;
    logic                     push_s, pop_s, rd_cap_s, rb_serve_s;
    logic                     wr_strobe_n_s, rd_strobe_n_s;
    logic [DATA_W-1:0]        rdata_r;
    logic [NUM_CH*DATA_W-1:0] shadow_r;
    logic [ADDR_W-1:0]        buf_addr_r [WBUF_DEPTH];
    logic [DATA_W-1:0]        buf_data_r [WBUF_DEPTH];

    // Addresses below BASE_ADDR wrap to a huge offset and fall outside SPAN
    assign off_s    = mem_addr - BASE_ADDR;
    assign hit_s    = (off_s < SPAN) && ((off_s & ALIGN_MASK) == {ADDR_W{1'b0}});
    assign ch_s     = CHW'(off_s >> SW);
    assign wr_hit_s = hit_s & mem_write;
    assign rd_hit_s = hit_s & mem_read & ~mem_write;
    assign mem_hit  = hit_s;

    assign full_s  = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
    assign empty_s = (wptr_r == rptr_r);
    assign push_s  = wr_hit_s & ~full_s;
    assign pop_s   = ((state_r == WR) || (state_r == RD_DRAIN)) & ~av_write_n & ~av_waitrequest;
    assign rd_cap_s = (state_r == RD) & ~av_read_n & ~av_waitrequest;
    assign wptr_n  = push_s ? (wptr_r + {{AW{1'b0}}, 1'b1}) : wptr_r;
    assign rptr_n  = pop_s  ? (rptr_r + {{AW{1'b0}}, 1'b1}) : rptr_r;
    assign empty_n = (wptr_n == rptr_n);

`ifdef MMIO_READBACK_EN
    assign rb_serve_s = rd_hit_s & empty_s & (state_r == IDLE);
`else
    assign rb_serve_s = 1'b0;
`endif

    assign wr_strobe_n_s = ((state_n == WR) || (state_n == RD_DRAIN)) && !empty_n;
    assign rd_strobe_n_s = (state_n == RD);
    assign shadow_out    = shadow_r;

    // Next-state logic
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (rd_hit_s && !rb_serve_s) begin
                    state_n = RD_DRAIN;
                end else if (!empty_s) begin
                    state_n = WR;
                end else begin
                    state_n = IDLE;
                end
            end
            WR: begin
                if (pop_s) begin
                    state_n = IDLE;
                end else begin
                    state_n = WR;
                end
            end
            RD_DRAIN: begin
                if (empty_n) begin
`ifdef MMIO_READBACK_EN
                    state_n = IDLE;
`else
                    state_n = RD;
`endif
                end else begin
                    state_n = RD_DRAIN;
                end
            end
            RD: begin
                if (rd_cap_s) begin
                    state_n = RD_DONE;
                end else begin
                    state_n = RD;
                end
            end
            RD_DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Stall and read-return data; RD_DONE is the cycle the core takes mem_rdata
    always_comb begin
        stall     = 1'b0;
        mem_rdata = rdata_r;
        if (wr_hit_s && full_s) begin
            stall = 1'b1;
        end else if (rd_hit_s && !rb_serve_s && (state_r != RD_DONE)) begin
            stall = 1'b1;
        end else begin
            stall = 1'b0;
        end
`ifdef MMIO_READBACK_EN
        if (rb_serve_s) begin
            mem_rdata = shadow_r[ch_s*DATA_W +: DATA_W];
        end else begin
            mem_rdata = rdata_r;
        end
`endif
    end

    // Write-buffer storage; validity is tracked by the pointers alone
    always_ff @(posedge clock) begin
        if (push_s) begin
            buf_addr_r[wptr_r[AW-1:0]] <= mem_addr;
            buf_data_r[wptr_r[AW-1:0]] <= mem_wdata;
        end
    end

    // State, pointers, registered Avalon outputs, read register and shadows
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_r      <= IDLE;
            wptr_r       <= {(AW+1){1'b0}};
            rptr_r       <= {(AW+1){1'b0}};
            av_address   <= {ADDR_W{1'b0}};
            av_writedata <= {DATA_W{1'b0}};
            av_read_n    <= 1'b1;
            av_write_n   <= 1'b1;
            rdata_r      <= {DATA_W{1'b0}};
            shadow_r     <= {(NUM_CH*DATA_W){1'b0}};
        end else begin
            state_r    <= state_n;
            wptr_r     <= wptr_n;
            rptr_r     <= rptr_n;
            av_write_n <= ~wr_strobe_n_s;
            av_read_n  <= ~rd_strobe_n_s;
            // Address/data load only when a new transfer starts
            if (wr_strobe_n_s && (av_write_n || pop_s)) begin
                av_address   <= buf_addr_r[rptr_n[AW-1:0]];
                av_writedata <= buf_data_r[rptr_n[AW-1:0]];
            end else if (rd_strobe_n_s && av_read_n) begin
                av_address <= mem_addr;
            end
            if (rd_cap_s) begin
                rdata_r <= av_readdata;
            end else if (state_r == RD_DONE) begin
                rdata_r <= {DATA_W{1'b0}};
            end
            if (push_s) begin
                shadow_r[ch_s*DATA_W +: DATA_W] <= mem_wdata;
            end
        end
    end

endmodule
